// File: rtl/regs_pend_scoreboard_pkg.sv
// regs_pend_scoreboard_pkg
// Shared constants for the integer register pending-write scoreboard:
//   RV_NREGS  - architectural integer register count
//   SB_PEND_W - default per-register pending counter width
//   SB_NCHK   - default number of lookup ports (rs1, rs2, rd)
//   SB_NREL   - default number of release ports (EX cancel, LSQ write-back)
// sb_sum_w() gives the width needed to evaluate cnt + inc - dec without wrap.
package regs_pend_scoreboard_pkg;

    localparam int RV_NREGS  = 32;
    localparam int SB_PEND_W = 2;
    localparam int SB_NCHK   = 3;
    localparam int SB_NREL   = 2;

    function automatic int sb_sum_w(input int pend_w, input int nrel);
        return pend_w + $clog2(nrel + 1);
    endfunction

endpackage

// File: rtl/regs_pend_scoreboard_counter.sv
// regs_pend_scoreboard_counter
// One saturating up/down pending-write counter for a single register.
// Ports:
//   clk_i, resetb_i  clock, asynchronous active-low reset
//   en_i             clock enable; counter holds when low
//   inc_i            allocate request (dropped internally when saturated)
//   dec_i            number of releases hitting this register this cycle
//   full_o           counter is all-ones (allocate would be refused)
//   nz_o             registered counter is nonzero
//   live_o           counter as seen by lookups: with REGS_PEND_SB_BYPASS_EN
//                    defined it is nonzero after this cycle's releases,
//                    otherwise it equals nz_o
//   uflow_o          this cycle's releases exceed cnt + inc (protocol error)
module regs_pend_scoreboard_counter #(
    parameter int PEND_W = 2,
    parameter int DW     = 2
) (
    input  logic          clk_i,
    input  logic          resetb_i,
    input  logic          en_i,
    input  logic          inc_i,
    input  logic [DW-1:0] dec_i,
    output logic          full_o,
    output logic          nz_o,
    output logic          live_o,
    output logic          uflow_o
);

    localparam int SW = PEND_W + DW;

    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]     sum_w;

    always_comb begin
        full_o  = &cnt_q;
        nz_o    = |cnt_q;
        // An allocate on a saturated counter is dropped, so cnt + inc never
        // exceeds all-ones and the truncation below is lossless.
        sum_w   = SW'(cnt_q) + SW'(inc_i & en_i & ~full_o);
        uflow_o = en_i & (sum_w < SW'(dec_i));
        cnt_d   = cnt_q;
        if (en_i) begin
            if (uflow_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = PEND_W'(sum_w - SW'(dec_i));
            end
        end
`ifdef REGS_PEND_SB_BYPASS_EN
        // Same-cycle releases are subtracted so the last release of a
        // register unblocks its consumer without waiting for the flop.
        live_o = SW'(cnt_q) > SW'(dec_i);
`else
        live_o = nz_o;
`endif
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regs_pend_scoreboard.sv
// regs_pend_scoreboard
// Pending-write scoreboard for the integer register file. Counts up to
// 2^PEND_W-1 outstanding long-latency writes per register (x0 never tracked),
// accepts NREL releases per cycle and answers NCHK busy lookups per cycle.
// Optional feature macro: REGS_PEND_SB_BYPASS_EN (same-cycle release bypass
// on busy_o; any_pend_o always reflects registered state only).
// Ports:
//   clk_i, resetb_i  clock, asynchronous active-low reset
//   clk_en_i         global enable; all state holds when low
//   alloc_i          allocate one pending write to alloc_addr_i
//   alloc_full_o     counter of alloc_addr_i saturated (independent of alloc_i)
//   rel_i            per-port release strobes, targets in rel_addr_i[k*AW +: AW]
//   chk_i            per-port lookup valid, addresses in chk_addr_i[k*AW +: AW]
//   busy_o           per-port: looked-up register has a pending write
//   any_pend_o       some counter is nonzero
//   err_o            sticky: release to a zero counter or allocate while full
// Handshake: alloc_i is a one-cycle request with no ready; the caller must
// hold off while alloc_full_o is high. Releases are fire-and-forget strobes.
module regs_pend_scoreboard
    import regs_pend_scoreboard_pkg::*;
#(
    parameter  int NREGS  = RV_NREGS,
    parameter  int NCHK   = SB_NCHK,
    parameter  int NREL   = SB_NREL,
    parameter  int PEND_W = SB_PEND_W,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic               clk_i,
    input  logic               resetb_i,
    input  logic               clk_en_i,
    input  logic               alloc_i,
    input  logic [AW-1:0]      alloc_addr_i,
    output logic               alloc_full_o,
    input  logic [NREL-1:0]    rel_i,
    input  logic [NREL*AW-1:0] rel_addr_i,
    input  logic [NCHK-1:0]    chk_i,
    input  logic [NCHK*AW-1:0] chk_addr_i,
    output logic [NCHK-1:0]    busy_o,
    output logic               any_pend_o,
    output logic               err_o
);

    localparam int DW = sb_sum_w(PEND_W, NREL) - PEND_W;

    // Index 0 of each vector is a constant-zero stand-in for x0.
    logic [NREGS-1:0] full_w;
    logic [NREGS-1:0] nz_w;
    logic [NREGS-1:0] live_w;
    logic [NREGS-1:0] uflow_w;

    assign full_w[0]  = 1'b0;
    assign nz_w[0]    = 1'b0;
    assign live_w[0]  = 1'b0;
    assign uflow_w[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_reg
        logic          inc;
        logic [DW-1:0] dec;

        // Address decode and per-register release popcount.
        always_comb begin
            inc = alloc_i && (alloc_addr_i == AW'(r));
            dec = '0;
            for (int k = 0; k < NREL; k++) begin
                if (clk_en_i && rel_i[k] && (rel_addr_i[k*AW +: AW] == AW'(r))) begin
                    dec = dec + DW'(1);
                end
            end
        end

        regs_pend_scoreboard_counter #(
            .PEND_W (PEND_W),
            .DW     (DW)
        ) u_cnt (
            .clk_i    (clk_i),
            .resetb_i (resetb_i),
            .en_i     (clk_en_i),
            .inc_i    (inc),
            .dec_i    (dec),
            .full_o   (full_w[r]),
            .nz_o     (nz_w[r]),
            .live_o   (live_w[r]),
            .uflow_o  (uflow_w[r])
        );
    end

    // Lookup muxes; x0 maps onto the zero entries and so is never busy/full.
    always_comb begin
        alloc_full_o = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (alloc_addr_i == AW'(r)) begin
                alloc_full_o = full_w[r];
            end
        end
        busy_o = '0;
        for (int k = 0; k < NCHK; k++) begin
            for (int r = 0; r < NREGS; r++) begin
                if (chk_i[k] && (chk_addr_i[k*AW +: AW] == AW'(r))) begin
                    busy_o[k] = live_w[r];
                end
            end
        end
    end

    assign any_pend_o = |nz_w;

    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (clk_en_i && ((alloc_i && alloc_full_o) || (|uflow_w))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_regs_pend_scoreboard.sv
// tb_regs_pend_scoreboard
// Directed scenarios followed by randomized traffic, compared every cycle
// against a counter-per-register reference model.
module tb_regs_pend_scoreboard;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NCHK  = 3;
    localparam int NREL  = 2;
    localparam int MAXC  = 3;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic resetb_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic               clk_en_i;
    logic               alloc_i;
    logic [AW-1:0]      alloc_addr_i;
    logic               alloc_full_o;
    logic [NREL-1:0]    rel_i;
    logic [NREL*AW-1:0] rel_addr_i;
    logic [NCHK-1:0]    chk_i;
    logic [NCHK*AW-1:0] chk_addr_i;
    logic [NCHK-1:0]    busy_o;
    logic               any_pend_o;
    logic               err_o;

    regs_pend_scoreboard dut (
        .clk_i        (clk_i),
        .resetb_i     (resetb_i),
        .clk_en_i     (clk_en_i),
        .alloc_i      (alloc_i),
        .alloc_addr_i (alloc_addr_i),
        .alloc_full_o (alloc_full_o),
        .rel_i        (rel_i),
        .rel_addr_i   (rel_addr_i),
        .chk_i        (chk_i),
        .chk_addr_i   (chk_addr_i),
        .busy_o       (busy_o),
        .any_pend_o   (any_pend_o),
        .err_o        (err_o)
    );

    // ---------------- reference model ----------------
    int pend[NREGS];
    bit err_m;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rel_hits(input int r);
        int n = 0;
        if (!clk_en_i || r == 0) return 0;
        for (int k = 0; k < NREL; k++)
            if (rel_i[k] && int'(rel_addr_i[k*AW +: AW]) == r) n++;
        return n;
    endfunction

    function automatic int exp_busy_vec();
        int v = 0;
        for (int k = 0; k < NCHK; k++) begin
            int a = int'(chk_addr_i[k*AW +: AW]);
            int c = pend[a];
`ifdef REGS_PEND_SB_BYPASS_EN
            c = c - rel_hits(a);
`endif
            if (chk_i[k] && a != 0 && c > 0) v |= (1 << k);
        end
        return v;
    endfunction

    function automatic int exp_full();
        int a = int'(alloc_addr_i);
        return (a != 0 && pend[a] == MAXC) ? 1 : 0;
    endfunction

    function automatic int exp_any();
        for (int r = 1; r < NREGS; r++) if (pend[r] > 0) return 1;
        return 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        clk_en_i = 1'b1; alloc_i = 1'b0; alloc_addr_i = '0;
        rel_i = '0; rel_addr_i = '0; chk_i = '0; chk_addr_i = '0;
    endtask

    task automatic set_rel(input int k, input int a);
        rel_i[k] = 1'b1;
        rel_addr_i[k*AW +: AW] = AW'(a);
    endtask

    task automatic set_chk(input int k, input int a);
        chk_i[k] = 1'b1;
        chk_addr_i[k*AW +: AW] = AW'(a);
    endtask

    // Called just after a falling edge with inputs driven: checks outputs,
    // advances the model, and returns at the next falling edge.
    task automatic cycle(input string tag);
        #1;
        check({tag, ".busy"},  int'(busy_o),       exp_busy_vec());
        check({tag, ".full"},  int'(alloc_full_o), exp_full());
        check({tag, ".any"},   int'(any_pend_o),   exp_any());
        check({tag, ".err"},   int'(err_o),        int'(err_m));
        if (clk_en_i) begin
            if (alloc_i && exp_full() == 1) err_m = 1'b1;
            for (int r = 1; r < NREGS; r++) begin
                int up = (alloc_i && int'(alloc_addr_i) == r && pend[r] < MAXC) ? 1 : 0;
                int dn = rel_hits(r);
                if (pend[r] + up < dn) begin
                    pend[r] = 0;
                    err_m = 1'b1;
                end else begin
                    pend[r] = pend[r] + up - dn;
                end
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        resetb_i = 1'b0;
        #1;
        check({tag, ".rst_busy"}, int'(busy_o),       0);
        check({tag, ".rst_full"}, int'(alloc_full_o), 0);
        check({tag, ".rst_any"},  int'(any_pend_o),   0);
        check({tag, ".rst_err"},  int'(err_o),        0);
        foreach (pend[r]) pend[r] = 0;
        err_m = 1'b0;
        @(negedge clk_i);
        resetb_i = 1'b1;
    endtask

    int pick[6] = '{0, 3, 5, 7, 9, 12};

    initial begin
        idle();
        foreach (pend[r]) pend[r] = 0;
        err_m = 1'b0;
        @(negedge clk_i);
        set_chk(0, 5); set_chk(1, 1); alloc_addr_i = 5;
        do_reset("init");

        // x5: three allocates saturate, fourth is refused and flags error.
        idle(); alloc_i = 1'b1; alloc_addr_i = 5;
        for (int i = 0; i < 3; i++) cycle("x5_alloc");
        set_chk(0, 5);
        #1;
        check("x5_full_const", int'(alloc_full_o), 1);
        check("x5_busy_const", int'(busy_o[0]), 1);
        cycle("x5_alloc4");
        idle(); set_chk(0, 5); set_rel(1, 5);
        for (int i = 0; i < 3; i++) cycle("x5_rel");
        idle(); set_chk(0, 5);
        #1;
        check("x5_idle_busy_const", int'(busy_o[0]), 0);
        check("x5_err_const", int'(err_o), 1);
        cycle("x5_after");
        do_reset("r1");

        // x7: allocate and release together net out.
        idle(); alloc_i = 1'b1; alloc_addr_i = 7; cycle("x7_alloc");
        set_rel(0, 7); set_chk(2, 7); cycle("x7_net");
        idle(); set_chk(2, 7);
        #1; check("x7_busy_const", int'(busy_o[2]), 1);
        cycle("x7_hold");
        set_rel(0, 7); cycle("x7_rel");
        idle(); set_chk(2, 7); cycle("x7_clear");

        // x9: double release empties, a third underflows.
        idle(); alloc_i = 1'b1; alloc_addr_i = 9;
        cycle("x9_a1"); cycle("x9_a2");
        idle(); set_rel(0, 9); set_rel(1, 9); cycle("x9_rel2");
        idle();
        #1; check("x9_any_const", int'(any_pend_o), 0);
        cycle("x9_empty");
        set_rel(0, 9); cycle("x9_uflow");
        idle(); set_chk(1, 9);
        #1; check("x9_err_const", int'(err_o), 1);
        cycle("x9_after");
        do_reset("r2");

        // x0: ignored entirely.
        idle(); alloc_i = 1'b1; set_rel(0, 0); set_rel(1, 0); set_chk(0, 0);
        cycle("x0_ops");
        idle(); set_chk(0, 0);
        #1; check("x0_err_const", int'(err_o), 0);
        cycle("x0_after");

        // x3: same-cycle release visibility.
        idle(); alloc_i = 1'b1; alloc_addr_i = 3; cycle("x3_alloc");
        idle(); set_chk(0, 3); set_rel(1, 3);
        #1;
`ifdef REGS_PEND_SB_BYPASS_EN
        check("x3_bypass_const", int'(busy_o[0]), 0);
`else
        check("x3_nobypass_const", int'(busy_o[0]), 1);
`endif
        cycle("x3_rel");
        idle(); set_chk(0, 3); cycle("x3_next");

        // x12: clock enable low holds the counter against release strobes.
        idle(); alloc_i = 1'b1; alloc_addr_i = 12;
        cycle("x12_a1"); cycle("x12_a2");
        idle(); clk_en_i = 1'b0; set_rel(0, 12); set_rel(1, 12); set_chk(0, 12);
        for (int i = 0; i < 4; i++) cycle("x12_hold");
        idle(); set_chk(0, 12);
        #1; check("x12_busy_const", int'(busy_o[0]), 1);
        cycle("x12_en");
        set_rel(0, 12); alloc_i = 1'b1; alloc_addr_i = 5; cycle("x12_burst");
        set_rel(0, 12); set_rel(1, 5); set_chk(1, 5); set_chk(0, 12);
        do_reset("x12_mid");

        // Randomized traffic over a small set of colliding registers.
        for (int i = 0; i < 600; i++) begin
            idle();
            clk_en_i     = ($urandom_range(0, 99) < 85);
            alloc_i      = $urandom_range(0, 1);
            alloc_addr_i = AW'(pick[$urandom_range(0, 5)]);
            for (int k = 0; k < NREL; k++)
                if ($urandom_range(0, 99) < 35) set_rel(k, pick[$urandom_range(0, 5)]);
            for (int k = 0; k < NCHK; k++)
                if ($urandom_range(0, 99) < 80) set_chk(k, pick[$urandom_range(0, 5)]);
            cycle("rand");
            if (i % 150 == 149) do_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
